// File: rtl/mw_writeback.sv
// M->W pipeline register plus writeback datapath (load extract/extend, lwl/lwr merge, result select).
// Latency: M inputs captured on edge N; instr_w and rf_*/fwd_* valid during cycle N+1 (rf_* combinational from decoder).
// Backpressure: stall_w holds every W register; flush_w loads a bubble and wins over stall. Optional MW_RETIRE_CNT_EN adds retire_cnt.
module mw_writeback (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_w,
  input  logic        flush_w,
  input  logic [31:0] instr_m,
  input  logic [31:0] pc8_m,
  input  logic [31:0] alu_m,
  input  logic [31:0] dm_rdata_m,
  input  logic [31:0] rt_val_m,
  input  logic [31:0] hi_m,
  input  logic [31:0] lo_m,
  input  logic [4:0]  wreg_m,
  input  logic        cond_m,
  input  logic        valid_m,
  output logic [31:0] instr_w,
  input  logic        regwrite_w,
  input  logic [1:0]  lwmode_w,
  input  logic [1:0]  bextmode_w,
  input  logic [2:0]  memtoreg_w,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data
`ifdef MW_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  logic [31:0] r_instr, r_pc8, r_alu, r_dm, r_rtv, r_hi, r_lo;
  logic [4:0]  r_wreg;
  logic        r_cond, r_valid;

  logic [1:0]  w_k;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_zext;
  logic [31:0] w_lwl, w_lwr, w_mem, w_sel;
  logic        w_we;

  // W pipeline register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!reset_n || flush_w) begin
      r_instr <= '0;
      r_pc8   <= '0;
      r_alu   <= '0;
      r_dm    <= '0;
      r_rtv   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wreg  <= '0;
      r_cond  <= 1'b0;
      r_valid <= 1'b0;
    end else if (!stall_w) begin
      r_instr <= instr_m;
      r_pc8   <= pc8_m;
      r_alu   <= alu_m;
      r_dm    <= dm_rdata_m;
      r_rtv   <= rt_val_m;
      r_hi    <= hi_m;
      r_lo    <= lo_m;
      r_wreg  <= wreg_m;
      r_cond  <= cond_m;
      r_valid <= valid_m;
    end
  end

`ifdef MW_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count W-slot instructions that leave the slot (not held by stall); wraps naturally
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_retire_cnt <= '0;
    else if (r_valid && (!stall_w || flush_w))
      r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

  assign instr_w = r_instr;
  assign w_k     = r_alu[1:0];
  assign w_zext  = r_instr[28];   // lbu/lhu opcodes have bit 28 set

  // Byte/half pick from the aligned word, little-endian
  always_comb begin
    w_byte = r_dm[7:0];
    case (w_k)
      2'd0: w_byte = r_dm[7:0];
      2'd1: w_byte = r_dm[15:8];
      2'd2: w_byte = r_dm[23:16];
      2'd3: w_byte = r_dm[31:24];
      default: w_byte = r_dm[7:0];
    endcase
    w_half = r_alu[1] ? r_dm[31:16] : r_dm[15:0];
  end

  // Unaligned-load merges against the forwarded rt value
  always_comb begin
    w_lwl = r_dm;
    w_lwr = r_dm;
    case (w_k)
      2'd0: begin w_lwl = {r_dm[7:0],  r_rtv[23:0]}; w_lwr = r_dm;                         end
      2'd1: begin w_lwl = {r_dm[15:0], r_rtv[15:0]}; w_lwr = {r_rtv[31:24], r_dm[31:8]};  end
      2'd2: begin w_lwl = {r_dm[23:0], r_rtv[7:0]};  w_lwr = {r_rtv[31:16], r_dm[31:16]}; end
      2'd3: begin w_lwl = r_dm;                       w_lwr = {r_rtv[31:8],  r_dm[31:24]}; end
      default: begin w_lwl = r_dm; w_lwr = r_dm; end
    endcase
  end

  // Memory result: lwl/lwr override the byte/half extension mode
  always_comb begin
    w_mem = r_dm;
    if (lwmode_w == 2'b01)
      w_mem = w_lwl;
    else if (lwmode_w == 2'b10)
      w_mem = w_lwr;
    else if (bextmode_w == 2'b01)
      w_mem = {{24{~w_zext & w_byte[7]}}, w_byte};
    else if (bextmode_w == 2'b10)
      w_mem = {{16{~w_zext & w_half[15]}}, w_half};
  end

  // Result select
  always_comb begin
    w_sel = '0;
    case (memtoreg_w)
      3'b001:  w_sel = r_alu;
      3'b010:  w_sel = w_mem;
      3'b011:  w_sel = r_pc8;
      3'b100:  w_sel = r_hi;
      3'b101:  w_sel = r_lo;
      default: w_sel = '0;
    endcase
  end

  // Write port is fully zeroed when no write happens so the hazard unit never sees stale data
  assign w_we      = regwrite_w & r_valid & r_cond & (r_wreg != 5'd0);
  assign rf_we     = w_we;
  assign rf_wa     = w_we ? r_wreg : 5'd0;
  assign rf_wd     = w_we ? w_sel  : 32'd0;
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_wa;
  assign fwd_data  = rf_wd;

endmodule

// File: tb/tb_mw_writeback.sv
// Self-checking bench for mw_writeback: directed cases with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the W slot and the writeback rules.
// Works with or without MW_RETIRE_CNT_EN.
module tb_mw_writeback;

  logic        clk = 1'b0;
  logic        reset_n, stall_w, flush_w;
  logic [31:0] instr_m, pc8_m, alu_m, dm_rdata_m, rt_val_m, hi_m, lo_m;
  logic [4:0]  wreg_m;
  logic        cond_m, valid_m;
  logic [31:0] instr_w;
  logic        regwrite_w;
  logic [1:0]  lwmode_w, bextmode_w;
  logic [2:0]  memtoreg_w;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_wa, fwd_addr;
  logic [31:0] rf_wd, fwd_data;
`ifdef MW_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  mw_writeback dut (
    .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
    .instr_m(instr_m), .pc8_m(pc8_m), .alu_m(alu_m), .dm_rdata_m(dm_rdata_m),
    .rt_val_m(rt_val_m), .hi_m(hi_m), .lo_m(lo_m), .wreg_m(wreg_m),
    .cond_m(cond_m), .valid_m(valid_m), .instr_w(instr_w),
    .regwrite_w(regwrite_w), .lwmode_w(lwmode_w), .bextmode_w(bextmode_w),
    .memtoreg_w(memtoreg_w), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`ifdef MW_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr, pc8, alu, dm, rtv, hi, lo;
    logic [4:0]  wreg;
    logic        cond, valid;
  } wst_t;

  wst_t        ms;
  logic [31:0] m_cnt;
  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory result from the load rules, expressed with shifts and masks
  function automatic logic [31:0] mem_res(input wst_t s, input logic [1:0] lm, input logic [1:0] bm);
    logic [63:0] dm64, rt64, r;
    logic [31:0] v;
    int k, sh;
    dm64 = {32'd0, s.dm};
    rt64 = {32'd0, s.rtv};
    k = int'(s.alu[1:0]);
    if (lm == 2'b01) begin
      sh = 8 * (3 - k);
      r = (dm64 << sh) | (rt64 & ((64'd1 << sh) - 64'd1));
      return r[31:0];
    end
    if (lm == 2'b10) begin
      sh = 8 * k;
      r = (dm64 >> sh) | (rt64 & ~(64'h0000_0000_FFFF_FFFF >> sh));
      return r[31:0];
    end
    if (bm == 2'b01) begin
      v = (s.dm >> (8 * k)) & 32'hFF;
      if (!s.instr[28] && v >= 32'h80) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (bm == 2'b10) begin
      v = s.alu[1] ? (s.dm >> 16) : (s.dm & 32'hFFFF);
      if (!s.instr[28] && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    return s.dm;
  endfunction

  function automatic logic [31:0] sel_res(input wst_t s);
    case (memtoreg_w)
      3'd1: return s.alu;
      3'd2: return mem_res(s, lwmode_w, bextmode_w);
      3'd3: return s.pc8;
      3'd4: return s.hi;
      3'd5: return s.lo;
      default: return 32'd0;
    endcase
  endfunction

  // Model of the W slot and retire count, advanced at each rising edge
  task automatic model_update();
    if (!reset_n) m_cnt = 32'd0;
    else if (ms.valid && (!stall_w || flush_w)) m_cnt = m_cnt + 32'd1;
    if (!reset_n || flush_w) ms = '0;
    else if (!stall_w)
      ms = '{instr: instr_m, pc8: pc8_m, alu: alu_m, dm: dm_rdata_m, rtv: rt_val_m,
             hi: hi_m, lo: lo_m, wreg: wreg_m, cond: cond_m, valid: valid_m};
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_we;
      logic [31:0] e_wd;
      logic [4:0]  e_wa;
      e_we = regwrite_w && ms.valid && ms.cond && (ms.wreg != 5'd0);
      e_wa = e_we ? ms.wreg : 5'd0;
      e_wd = e_we ? sel_res(ms) : 32'd0;
      chk("instr_w", instr_w, ms.instr);
      chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      chk("rf_wa", {27'd0, rf_wa}, {27'd0, e_wa});
      chk("rf_wd", rf_wd, e_wd);
      chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_we});
      chk("fwd_addr", {27'd0, fwd_addr}, {27'd0, e_wa});
      chk("fwd_data", fwd_data, e_wd);
`ifdef MW_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, m_cnt);
`endif
    end
  end

  // One cycle: edge, then decoder outputs settle, then sample at the falling edge
  task automatic step(input logic rw, input logic [1:0] lm, input logic [1:0] bm, input logic [2:0] mr);
    @(posedge clk);
    model_update();
    #1;
    regwrite_w = rw; lwmode_w = lm; bextmode_w = bm; memtoreg_w = mr;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic set_m(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] rtv, input logic [4:0] wr, input logic c, input logic v);
    instr_m = ins; alu_m = alu; dm_rdata_m = dm; rt_val_m = rtv;
    wreg_m = wr; cond_m = c; valid_m = v;
  endtask

  logic [31:0] c0;

  initial begin
    ms = '0; m_cnt = 32'd0;
    reset_n = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    pc8_m = 32'h0040_0010; hi_m = 32'hDEAD_0001; lo_m = 32'hBEEF_0002;
    set_m(32'h0109_5021, 32'h5555_AAAA, 32'h1234_5678, 32'h8765_4321, 5'd7, 1'b1, 1'b1);
    regwrite_w = 1'b1; lwmode_w = 2'b00; bextmode_w = 2'b00; memtoreg_w = 3'd1;

    // Reset with nonzero inputs
    step(1'b1, 2'b00, 2'b00, 3'd1);
    step(1'b1, 2'b00, 2'b00, 3'd1);
    chk("rst_instr_w", instr_w, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    reset_n = 1'b1;

    // addu
    set_m(32'h0109_5021, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1);
    step(1'b1, 2'b00, 2'b00, 3'd1);
    chk("addu_we", {31'd0, rf_we}, 32'd1);
    chk("addu_wa", {27'd0, rf_wa}, 32'd8);
    chk("addu_wd", rf_wd, 32'h1234_5678);

    // lb / lbu
    set_m(32'h8000_0000, 32'h1000_0002, 32'h80FF_7F01, 32'h0, 5'd9, 1'b1, 1'b1);
    step(1'b1, 2'b00, 2'b01, 3'd2);
    chk("lb_k2", rf_wd, 32'hFFFF_FFFF);
    alu_m = 32'h1000_0003;
    step(1'b1, 2'b00, 2'b01, 3'd2);
    chk("lb_k3", rf_wd, 32'hFFFF_FF80);
    instr_m = 32'h9000_0000;
    step(1'b1, 2'b00, 2'b01, 3'd2);
    chk("lbu_k3", rf_wd, 32'h0000_0080);

    // lwl / lwr
    set_m(32'h8800_0000, 32'h2000_0001, 32'hAABB_CCDD, 32'h1122_3344, 5'd10, 1'b1, 1'b1);
    step(1'b1, 2'b01, 2'b00, 3'd2);
    chk("lwl_k1", rf_wd, 32'hCCDD_3344);
    instr_m = 32'h9800_0000;
    step(1'b1, 2'b10, 2'b00, 3'd2);
    chk("lwr_k1", rf_wd, 32'h11AA_BBCC);

    // movz not taken, then write to $0
    set_m(32'h0109_500A, 32'h7777_7777, 32'h0, 32'h0, 5'd11, 1'b0, 1'b1);
    step(1'b1, 2'b00, 2'b00, 3'd1);
    chk("movz_we", {31'd0, rf_we}, 32'd0);
    chk("movz_wd", rf_wd, 32'd0);
    set_m(32'h0109_0021, 32'h7777_7777, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    step(1'b1, 2'b00, 2'b00, 3'd1);
    chk("r0_we", {31'd0, rf_we}, 32'd0);

    // Stall holds outputs while inputs keep changing
    set_m(32'h0109_5021, 32'hAAAA_5555, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1);
    step(1'b1, 2'b00, 2'b00, 3'd1);
    c0 = m_cnt;
    stall_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m($urandom, $urandom, $urandom, $urandom, 5'(i + 20), 1'b1, 1'b1);
      step(1'b1, 2'b00, 2'b00, 3'd1);
      chk("stall_wd", rf_wd, 32'hAAAA_5555);
      chk("stall_wa", {27'd0, rf_wa}, 32'd8);
`ifdef MW_RETIRE_CNT_EN
      chk("stall_cnt", retire_cnt, c0);
`endif
    end
    stall_w = 1'b0;
    step(1'b1, 2'b00, 2'b00, 3'd1);
`ifdef MW_RETIRE_CNT_EN
    chk("release_cnt", retire_cnt, c0 + 32'd1);
`endif

    // Flush beats stall
    stall_w = 1'b1; flush_w = 1'b1;
    step(1'b1, 2'b00, 2'b00, 3'd1);
    chk("flush_we", {31'd0, rf_we}, 32'd0);
    chk("flush_instr", instr_w, 32'd0);
    stall_w = 1'b0; flush_w = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      stall_w = ($urandom_range(0, 3) == 0);
      flush_w = ($urandom_range(0, 7) == 0);
      set_m($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
      pc8_m = $urandom; hi_m = $urandom; lo_m = $urandom;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
